// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer
//   Command-driven controller for an 8-bit universal shift register. It takes
//   one command at a time and runs a load, an N-step shift or an 8-bit serial
//   capture on the shifter. The resulting byte comes back on a valid/ready
//   response channel.
//
//   Optional feature macro: SRSEQ_ROTATE_EN. When it is defined, the
//   cmd_rotate port exists and shift steps can feed back the outgoing bit,
//   which turns the shift into a rotate.
//
// Ports
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (ready only in IDLE)
//   cmd_op              : 00 shr, 01 shl, 10 serial capture, 11 load only
//   cmd_count           : shift steps (0 = load only, 9..15 clamp to 8)
//   cmd_data            : initial byte loaded before shifting
//   cmd_serial          : serial bit source
//   cmd_rotate          : rotate instead of shift (SRSEQ_ROTATE_EN only)
//   rsp_valid/rsp_ready : response handshake
//   rsp_data            : registered result byte
//   busy                : high in every state except IDLE
//   sr_select, sr_serial_in, sr_parallel_in : drive of the shifter
//   sr_parallel_output  : shifter output

module shift_reg_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [3:0] cmd_count,
   input  logic [7:0] cmd_data,
   input  logic [7:0] cmd_serial,
`ifdef SRSEQ_ROTATE_EN
   input  logic       cmd_rotate,
`endif
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       busy,
   output logic [1:0] sr_select,
   output logic       sr_serial_in,
   output logic [7:0] sr_parallel_in,
   input  logic [7:0] sr_parallel_output
);

   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned OP_W   = 2;

   localparam logic [OP_W-1:0]  SEL_SHR  = 2'b00;
   localparam logic [OP_W-1:0]  SEL_CAP  = 2'b10;
   localparam logic [OP_W-1:0]  SEL_LOAD = 2'b11;
   localparam logic [CNT_W-1:0] MAX_CNT  = 4'd8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      SHIFT  = 3'd2,
      CAP    = 3'd3,
      FLUSH  = 3'd4,
      SAMPLE = 3'd5,
      RESP   = 3'd6
   } state_t;

   state_t            state;
   logic [OP_W-1:0]   op_q;
   logic [CNT_W-1:0]  lim_q;     // clamped shift count
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] serial_q;
   logic [CNT_W-1:0]  step;
`ifdef SRSEQ_ROTATE_EN
   logic              rot_q;
`endif

   // Sequencer state, latched command and response register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         op_q     <= '0;
         lim_q    <= '0;
         data_q   <= '0;
         serial_q <= '0;
         step     <= '0;
         rsp_data <= '0;
`ifdef SRSEQ_ROTATE_EN
         rot_q    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  op_q     <= cmd_op;
                  lim_q    <= (cmd_count > MAX_CNT) ? MAX_CNT : cmd_count;
                  data_q   <= cmd_data;
                  serial_q <= cmd_serial;
                  step     <= '0;
`ifdef SRSEQ_ROTATE_EN
                  rot_q    <= cmd_rotate;
`endif
                  state    <= (cmd_op == SEL_CAP) ? CAP : LOAD;
               end
            end
            LOAD: begin
               step  <= '0;
               // op 11 has op_q[1] set; op 10 never reaches LOAD
               state <= (!op_q[1] && (lim_q != '0)) ? SHIFT : SAMPLE;
            end
            SHIFT: begin
               step <= step + 4'd1;
               if (step == CNT_W'(lim_q - 4'd1)) state <= SAMPLE;
            end
            CAP: begin
               step <= step + 4'd1;
               if (step == 4'd7) state <= FLUSH;
            end
            FLUSH: begin
               state <= SAMPLE;
            end
            SAMPLE: begin
               rsp_data <= sr_parallel_output;
               state    <= RESP;
            end
            RESP: begin
               if (rsp_ready) state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Status outputs decoded straight from the state register
   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign rsp_valid = (state == RESP);

   // Shifter drive for the current state; hold drive is the default
   always_comb begin
      sr_select      = SEL_LOAD;
      sr_parallel_in = sr_parallel_output;
      sr_serial_in   = 1'b0;
      case (state)
         LOAD: begin
            sr_parallel_in = data_q;
         end
         SHIFT: begin
            sr_select    = op_q;
            sr_serial_in = serial_q[step[2:0]];
`ifdef SRSEQ_ROTATE_EN
            // Feed the outgoing bit back in to rotate
            if (rot_q)
               sr_serial_in = (op_q == SEL_SHR) ? sr_parallel_output[0]
                                                : sr_parallel_output[DATA_W-1];
`endif
         end
         CAP: begin
            sr_select    = SEL_CAP;
            sr_serial_in = serial_q[3'd7 - step[2:0]];   // MSB first
         end
         FLUSH: begin
            // One extra serial-mode cycle moves the captured byte to the output
            sr_select = SEL_CAP;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/shift_reg_sequencer.md
# shift_reg_sequencer

Command-driven controller for the 8-bit universal shift register (`select`/`serial_in`/`parallel_in` → `parallel_output`). It accepts one command at a time over a valid/ready handshake and runs the load, N-step shift, or 8-bit serial-capture sequence on the shifter. It returns the resulting byte over a valid/ready response channel. It sits between a host/register interface and one shifter instance; the shifter's active-low reset is driven from `~reset` at integration.

## Interface
- No parameters; data width fixed at 8, shift count field 4 bits.
- `clk` input 1: rising-edge clock shared with the shifter.
- `reset` input 1: asynchronous, active-high.
- `cmd_valid` input 1: command offered.
- `cmd_ready` output 1: sequencer idle and able to accept.
- `cmd_op` input 2: 00 shift right, 01 shift left, 10 serial capture, 11 load only.
- `cmd_count` input 4: shift steps for ops 00/01; 0 means load only; 9–15 clamp to 8.
- `cmd_data` input 8: initial value loaded before shifting (ops 00/01/11).
- `cmd_serial` input 8: serial bit source. Step i of a shift uses bit i; capture sends bit 7 first.
- `cmd_rotate` input 1: present only with `SRSEQ_ROTATE_EN`.
- `rsp_valid` output 1: result available.
- `rsp_ready` input 1: result consumed.
- `rsp_data` output 8: registered result.
- `busy` output 1: high in every state except IDLE.
- `sr_select` output 2: drives the shifter `select`.
- `sr_serial_in` output 1: drives the shifter `serial_in`.
- `sr_parallel_in` output 8: drives the shifter `parallel_in`.
- `sr_parallel_output` input 8: the shifter `parallel_output`.

## Operation
- States: IDLE, LOAD, SHIFT, CAP, FLUSH, SAMPLE, RESP. The command fields, a 4-bit step counter and `rsp_data` are registered.
- **Hold drive.** Used in IDLE, SAMPLE and RESP: `sr_select`=11, `sr_parallel_in`=`sr_parallel_output`, `sr_serial_in`=0. The shifter output is stable in these states.
- **IDLE.**
  - `cmd_ready`=1.
  - On `cmd_valid`, latch all command fields.
  - Op 10 goes to CAP; all other ops go to LOAD.
- **LOAD.** One cycle.
  - Drive `sr_select`=11, `sr_parallel_in`=latched `cmd_data`.
  - Go to SHIFT if op is 00/01 and the clamped count is greater than 0; otherwise go to SAMPLE.
- **SHIFT.** Runs for the clamped count, 1–8 cycles.
  - Drive `sr_select`=latched op, `sr_parallel_in`=`sr_parallel_output` (feedback), `sr_serial_in`=`cmd_serial[step]`.
  - Go to SAMPLE after the last step.
- **CAP.** Runs 8 cycles.
  - Drive `sr_select`=10, `sr_serial_in`=`cmd_serial[7-step]`.
  - `sr_parallel_in` keeps the hold value.
- **FLUSH.** One cycle.
  - Drive `sr_select`=10, `sr_serial_in`=0. This copies the shifter's internal byte to its output.
- **SAMPLE.** One cycle; `rsp_data` <= `sr_parallel_output`.
- **RESP.**
  - `rsp_valid`=1 and `rsp_data` held stable until `rsp_valid && rsp_ready`; then go to IDLE.
  - `cmd_ready`=0 throughout, so no new command is taken in the same cycle as the response handshake.
- Reset at any time returns to IDLE and discards any command in progress.

## Timing
- Reset values:
  - State IDLE, `cmd_ready`=1, `busy`=0.
  - `rsp_valid`=0, `rsp_data`=0x00.
  - `sr_select`=11, `sr_serial_in`=0, `sr_parallel_in`=`sr_parallel_output`.
- T0 is the accept cycle (`cmd_valid && cmd_ready`).
- Shift op with clamped count N>0: LOAD at T1, SHIFT at T2..T(1+N), SAMPLE at T(2+N), `rsp_valid` first high at T(3+N).
- Load-only (op 11 or count 0): LOAD T1, SAMPLE T2, `rsp_valid` T3.
- Capture: CAP T1..T8, FLUSH T9, SAMPLE T10, `rsp_valid` T11.
- `rsp_valid` falls the cycle after the response handshake; `cmd_ready` rises in the same cycle.
- `cmd_*` inputs are ignored outside IDLE.
- Capture uses all 8 bits, so stale shifter contents never leak into the result.

## Configuration
- `SRSEQ_ROTATE_EN` defined:
  - The `cmd_rotate` port exists.
  - When a command is latched with `cmd_rotate`=1, each SHIFT step drives `sr_serial_in` from the outgoing bit, making the shift a rotate: `sr_parallel_output[0]` for op 00, `sr_parallel_output[7]` for op 01.
  - `cmd_serial` is ignored for that command.
  - Capture and load ignore `cmd_rotate`.
- `SRSEQ_ROTATE_EN` undefined: the port is absent and `sr_serial_in` always comes from `cmd_serial`.

## Test plan
- Shift right: op 00, `cmd_data`=0xA5, count 3, `cmd_serial`=0x05. Intermediates 0xD2, 0x69; `rsp_data`=0xB4 with `rsp_valid` at T6.
- Shift left: op 01, `cmd_data`=0x81, count 2, `cmd_serial`=0x02. Intermediate 0x02; `rsp_data`=0x05. Count 12 with `cmd_data`=0xFF, `cmd_serial`=0x00 clamps to 8 and gives 0x00 at T11.
- Capture: op 10, `cmd_serial`=0x3C. `sr_serial_in` sequence is 0,0,1,1,1,1,0,0 then 0 on FLUSH; `rsp_data`=0x3C at T11. A second capture of 0xC3 returns 0xC3.
- Backpressure: hold `rsp_ready`=0 for 5 cycles. `rsp_valid`/`rsp_data` stay stable, `cmd_ready`=0 and a concurrent `cmd_valid` is ignored. Releasing `rsp_ready` returns to IDLE the next cycle.
- Reset mid-SHIFT: assert `reset` at step 2. Next cycle shows IDLE, `rsp_valid`=0, `rsp_data`=0x00, `sr_select`=11, and no response is ever produced.
- With `SRSEQ_ROTATE_EN`: op 00, `cmd_data`=0x01, count 1, `cmd_rotate`=1 gives 0x80. Op 01, `cmd_data`=0x81, count 4, `cmd_rotate`=1 gives 0x18.
